// File: rtl/conversor_bin_bcd_8bits_if.sv
// Handshake and data bundle between the multiplier-side requester and the
// binary-to-BCD converter.
interface conversor_bin_bcd_8bits_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd
  );
endinterface

// File: rtl/conversor_bin_bcd_8bits.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one shift per clock).
// Takes the multiplier product and presents hundreds/tens/units digits that
// change only when a conversion completes.
module conversor_bin_bcd_8bits #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  conversor_bin_bcd_8bits_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] adjusted;
  logic [BCD_W-1:0] shifted;
  logic [BCD_W-1:0] bcd_q;
  logic [CNT_W-1:0] cnt;

  // Add 3 to every scratch digit >= 5, each judged on its pre-adjust value,
  // then form the next scratch by shifting in the binary MSB.
  always_comb begin
    adjusted = scratch;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
    shifted = {adjusted[BCD_W-2:0], shreg[WIDTH-1]};
  end

  // Control FSM plus shift/scratch/result registers; bcd is only written on
  // the final iteration so partial values never reach the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            shreg   <= bus.bin;
            scratch <= '0;
            cnt     <= CNT_W'(WIDTH);
            state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          scratch <= shifted;
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd_q <= shifted;
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == ST_CONV);
  assign bus.done = (state == ST_FIN);
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_conversor_bin_bcd_8bits.sv
// Scoreboard bench for the binary-to-BCD converter: a cycle-level timing model
// plus decimal arithmetic produce expectations, a monitor checks every cycle.
module tb_conversor_bin_bcd_8bits;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conversor_bin_bcd_8bits_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_if ();

  conversor_bin_bcd_8bits #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state
  int          timer   = 0;
  logic [11:0] cur_exp = '0;
  logic [11:0] ref_bcd = '0;
  logic [11:0] exp_q[$];
  int          cyc_cnt = 0;

  bit mon_en     = 0;
  bit spacing_en = 0;
  bit have_prev  = 0;
  int last_done  = 0;

  function automatic logic [11:0] to_bcd(int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: accepts start only when idle, finishes WIDTH+1 edges later.
  always @(posedge clk) begin
    cyc_cnt++;
    if (rst) begin
      timer   = 0;
      ref_bcd = '0;
      exp_q.delete();
    end else if (timer != 0) begin
      timer--;
      if (timer == 1) ref_bcd = cur_exp;
    end else if (bus_if.start) begin
      timer   = WIDTH + 1;
      cur_exp = to_bcd(int'(bus_if.bin));
      exp_q.push_back(cur_exp);
    end
  end

  // Monitor: timing and held value every cycle, result popped on done.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", int'(bus_if.busy), int'(timer >= 2));
      chk("done", int'(bus_if.done), int'(timer == 1));
      chk("bcd_hold", int'(bus_if.bcd), int'(ref_bcd));
      if (bus_if.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          logic [11:0] e;
          logic [11:0] b;
          e = exp_q.pop_front();
          b = bus_if.bcd;
          chk("bcd_result", int'(b), int'(e));
          chk("digits_legal", int'(b[3:0] <= 4'd9 && b[7:4] <= 4'd9 && b[11:8] <= 4'd9), 1);
        end
        if (spacing_en && have_prev) chk("done_spacing", cyc_cnt - last_done, WIDTH + 2);
        have_prev = 1;
        last_done = cyc_cnt;
      end
    end
  end

  task automatic convert(int v, int gap);
    bus_if.start = 1'b1;
    bus_if.bin   = WIDTH'(v);
    cyc(1);
    bus_if.start = 1'b0;
    bus_if.bin   = WIDTH'($urandom);
    cyc(gap);
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.bin   = '0;
    rst          = 1'b1;
    cyc(2);
    rst    = 1'b0;
    mon_en = 1;
    cyc(1);

    // Basic values
    convert(0, 11);
    convert(255, 11);
    convert(225, 11);
    convert(81, 11);

    // Starts during busy and on the done cycle are ignored
    bus_if.start = 1'b1; bus_if.bin = 8'd100; cyc(1);
    bus_if.start = 1'b0; cyc(2);
    bus_if.start = 1'b1; bus_if.bin = 8'd7; cyc(1);
    bus_if.start = 1'b0; cyc(3);
    bus_if.start = 1'b1; cyc(1);
    bus_if.start = 1'b0; cyc(1);
    bus_if.start = 1'b1; cyc(1);
    bus_if.start = 1'b0; cyc(5);

    // Reset mid-conversion aborts, then a clean conversion
    bus_if.start = 1'b1; bus_if.bin = 8'd199; cyc(1);
    bus_if.start = 1'b0; cyc(3);
    rst = 1'b1; cyc(1);
    rst = 1'b0; cyc(3);
    convert(42, 11);

    // Held start: back-to-back conversions WIDTH+2 apart
    have_prev  = 0;
    spacing_en = 1;
    bus_if.start = 1'b1; bus_if.bin = 8'd99; cyc(5);
    bus_if.bin = 8'd200; cyc(20);
    bus_if.start = 1'b0; cyc(12);
    spacing_en = 0;

    // Exhaustive sweep
    for (int v = 0; v < 256; v++) convert(v, 10);

    // Random values with random stray start pulses
    for (int n = 0; n < 60; n++) begin
      bus_if.start = 1'b1;
      bus_if.bin   = WIDTH'($urandom);
      cyc(1);
      for (int k = 0; k < 9 + int'($urandom_range(0, 3)); k++) begin
        bus_if.start = ($urandom_range(0, 3) == 0);
        bus_if.bin   = WIDTH'($urandom);
        cyc(1);
      end
      bus_if.start = 1'b0;
      cyc(11);
    end

    cyc(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
